goofy_mem_arbiter: RTL and testbench
====================================

Name: goofy_mem_arbiter

Overview:
- Shares the single-port GoofyRam (16-bit address, 8-bit data) between up to NUM_REQ requesters: core fetch, core data and I/O-DMA.
- Uses round-robin arbitration with a bounded lock for multi-byte bursts, such as 16-bit operand fetch.
- Grants combinationally with a valid/ready style handshake. Tracks the RAM's one-cycle read latency and returns data to the winning requester.
- Sits between the core/DMA and the RAM, replacing direct core-to-RAM wiring.

Parameters:
- NUM_REQ, 3, number of requesters (1..4); index 0 = fetch, 1 = data, 2 = DMA.
- AW, 16, address width.
- DW, 8, data width.
- MAX_HOLD, 4, maximum consecutive locked beats before forced rotation (>=1).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- res, input, 1: synchronous active-low reset.
- req, input, NUM_REQ: per-requester access request.
- lock, input, NUM_REQ: per-requester request to keep ownership after the current beat.
- we, input, NUM_REQ: 1 = write beat, 0 = read beat.
- addr, input, NUM_REQ*AW: flattened addresses; requester i uses bits [i*AW +: AW].
- wdata, input, NUM_REQ*DW: flattened write data.
- gnt, output, NUM_REQ: one-hot combinational grant; a beat transfers on an edge where req[i] & gnt[i].
- rvalid, output, NUM_REQ: one-hot read-data valid, registered.
- rdata, output, DW: read data, valid with any rvalid bit.
- owner, output, 2: index of the current grantee; meaningful only when |gnt.
- busy, output, 1: |req.
- ram_addr, output, AW: to the RAM address.
- ram_save, output, 1: to the RAM write enable.
- ram_in, output, DW: to the RAM write data.
- ram_out, input, DW: from the RAM; valid one cycle after the address is presented.

Behaviour:
- Reset values (res==0 at an edge):
  - Registers clear: ptr=0, hold_cnt=0, lock_valid=0, last=0, rvalid=0.
  - Combinational outputs are gated while res==0: gnt=0, ram_save=0.
- One RAM access per cycle. ram_addr, ram_in, ram_save = addr/wdata/(we & req) of the granted requester; ram_addr and ram_in are 0 when nothing is granted.
- Grant selection (combinational, each cycle):
  - Case a, lock continues: if lock_valid & req[last] & (hold_cnt < MAX_HOLD), grant last.
  - Case b, round-robin: otherwise pick the first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - Case c, forced rotation fallback: if case (a) was blocked only by hold_cnt==MAX_HOLD and no other requester is active, grant last anyway. There is no idle bubble.
- On an accepted beat w (req[w] & gnt[w] at an edge):
  - last<=w; ptr<=(w+1) mod NUM_REQ.
  - If lock[w]: lock_valid<=1 and hold_cnt<=(lock_valid & last==w & hold_cnt<MAX_HOLD) ? hold_cnt+1 : 1.
  - If !lock[w]: lock_valid<=0 and hold_cnt<=0.
- If the lock owner drops req, the lock releases immediately: round-robin applies in that same cycle and lock_valid clears at the next edge.
- Read latency: a read accepted at edge N gives rvalid[w]=1 for exactly the cycle after edge N. rdata is ram_out passthrough.
  - Back-to-back reads from different owners give consecutive rvalid pulses, each on the correct index.
- Write beats never assert rvalid.
- No cycle ever has more than one gnt bit or more than one rvalid bit set.
- Reset mid-operation: a pending rvalid is discarded and the lock is dropped.
- Requester indices >= NUM_REQ never win. With NUM_REQ=1, gnt[0]=req[0] whenever res==1.
- ptr, last and owner are 2 bits wide; indices wrap modulo NUM_REQ, not 4.

Test Plan:
- Single read: RAM[0x1234]=0x5A, req[0]=1, we=0, addr=0x1234 for one cycle -> gnt[0]=1 and ram_addr=0x1234 that cycle; next cycle rvalid=3'b001, rdata=0x5A.
- Round-robin: req=3'b111 held with lock=0 for 6 cycles -> owner sequence 0,1,2,0,1,2; rvalid follows one cycle behind.
- Lock bound: MAX_HOLD=4; req1 lock=1 for 6 beats; req0 and req2 continuously requesting -> owner 1,1,1,1,2,0,1,1.
- Write then read: req2 we=1 addr=0x00FF wdata=0xC3 -> ram_save=1 for exactly one cycle, rvalid stays 0; then req0 read 0x00FF -> rdata=0xC3 with rvalid[0].
- Reset: read accepted, then res=0 on the next edge with req=3'b111 held -> rvalid=0, gnt=0 throughout reset; after release, first grant goes to index 0.
- Lock release: req1 locked after 2 beats drops req while req0 is waiting -> gnt[0]=1 in that same cycle, no idle cycle.

Source files
------------

// File: rtl/goofy_mem_arbiter.sv
// goofy_mem_arbiter: shares the single-port GoofyRam between up to four requesters.
// Round-robin grant with a bounded burst lock, combinational grant, and one-cycle
// read-data return steered to the requester whose read was accepted.
module goofy_mem_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    lock,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic [1:0]            owner,
  output logic                  busy,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_save,
  output logic [DW-1:0]         ram_in,
  input  logic [DW-1:0]         ram_out
);

  localparam int unsigned   HW      = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MaxHold = HW'(MAX_HOLD);
  localparam logic [1:0]    LastIdx = 2'(NUM_REQ - 1);

  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         last_q, last_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               lock_valid_q, lock_valid_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  logic [1:0] sel;
  logic [1:0] cand;
  logic       found;
  logic       lock_cont;
  logic       accept;

  // Winner selection: continue an unexpired lock, else round-robin from ptr.
  // When the lock has expired and the owner is the only requester, the scan
  // lands on it anyway, so there is never an idle bubble.
  always_comb begin
    sel       = '0;
    cand      = '0;
    found     = 1'b0;
    lock_cont = lock_valid_q && req[last_q] && (hold_q < MaxHold);
    if (lock_cont) begin
      sel   = last_q;
      found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = 2'((int'(ptr_q) + k) % NUM_REQ);
        if (!found && req[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  // Grant and RAM-side muxing, all forced quiet while reset is asserted.
  always_comb begin
    gnt      = '0;
    ram_addr = '0;
    ram_in   = '0;
    ram_save = 1'b0;
    accept   = res && found;
    if (accept) begin
      gnt[sel] = 1'b1;
      ram_addr = addr[sel*AW +: AW];
      ram_in   = wdata[sel*DW +: DW];
      ram_save = we[sel];
    end
  end

  // Next-state for rotation pointer, lock tracking and read-return pulse.
  always_comb begin
    ptr_d        = ptr_q;
    last_d       = last_q;
    hold_d       = hold_q;
    lock_valid_d = lock_valid_q;
    rvalid_d     = '0;
    if (accept) begin
      last_d = sel;
      ptr_d  = (sel == LastIdx) ? 2'd0 : sel + 2'd1;
      if (lock[sel]) begin
        lock_valid_d = 1'b1;
        hold_d = (lock_valid_q && (last_q == sel) && (hold_q < MaxHold)) ?
                 hold_q + 1'b1 : HW'(1);
      end else begin
        lock_valid_d = 1'b0;
        hold_d       = '0;
      end
      if (!we[sel]) begin
        rvalid_d[sel] = 1'b1;
      end
    end else begin
      // No beat means the lock owner is not requesting: release the lock.
      lock_valid_d = 1'b0;
      hold_d       = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      ptr_q        <= '0;
      last_q       <= '0;
      hold_q       <= '0;
      lock_valid_q <= 1'b0;
      rvalid_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      lock_valid_q <= lock_valid_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = ram_out;
  assign owner  = sel;
  assign busy   = |req;

endmodule

// File: tb/tb_goofy_mem_arbiter.sv
// Randomised bench for goofy_mem_arbiter with a behavioural RAM and reference model.
module tb_goofy_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MH = 4;

  logic            clk = 1'b0;
  logic            res;
  logic [N-1:0]    req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic [1:0]      owner;
  logic            busy;
  logic [AW-1:0]   ram_addr;
  logic            ram_save;
  logic [DW-1:0]   ram_in;
  logic [DW-1:0]   ram_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem     [65536];
  logic [7:0] exp_mem [65536];

  // Reference state kept as plain integers.
  int m_ptr, m_last, m_hold, m_rv;
  bit m_lockv;
  logic [7:0] m_rdata;

  goofy_mem_arbiter #(
    .NUM_REQ (N),
    .AW      (AW),
    .DW      (DW),
    .MAX_HOLD(MH)
  ) dut (
    .clk     (clk),
    .res     (res),
    .req     (req),
    .lock    (lock),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .owner   (owner),
    .busy    (busy),
    .ram_addr(ram_addr),
    .ram_save(ram_save),
    .ram_in  (ram_in),
    .ram_out (ram_out)
  );

  always #5 clk = ~clk;

  // GoofyRam: registered read, one-cycle latency.
  always @(posedge clk) begin
    if (ram_save) mem[ram_addr] <= ram_in;
    ram_out <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int i);
    return wdata[i*DW +: DW];
  endfunction

  // Winner under the current inputs, or -1 when nobody is granted.
  function automatic int m_grant();
    if (!res) return -1;
    if (m_lockv && req[m_last] && m_hold < MH) return m_last;
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic void m_edge(input int w);
    m_rv = -1;
    if (!res) begin
      m_ptr = 0; m_last = 0; m_hold = 0; m_lockv = 0;
      return;
    end
    if (w < 0) begin
      m_lockv = 0; m_hold = 0;
      return;
    end
    if (we[w]) exp_mem[addr_of(w)] = wdata_of(w);
    else begin
      m_rv    = w;
      m_rdata = exp_mem[addr_of(w)];
    end
    if (lock[w]) begin
      m_hold  = (m_lockv && m_last == w && m_hold < MH) ? m_hold + 1 : 1;
      m_lockv = 1;
    end else begin
      m_hold  = 0;
      m_lockv = 0;
    end
    m_last = w;
    m_ptr  = (w + 1) % N;
  endfunction

  // One clock: check outputs mid-cycle, advance the model at the edge.
  task automatic cycle();
    int g;
    logic [N-1:0] eg, erv;
    @(negedge clk);
    g   = m_grant();
    eg  = (g >= 0) ? N'(1 << g) : '0;
    erv = (m_rv >= 0) ? N'(1 << m_rv) : '0;
    check("gnt", 32'(gnt), 32'(eg));
    check("ram_addr", 32'(ram_addr), (g >= 0) ? 32'(addr_of(g)) : 32'd0);
    check("ram_in", 32'(ram_in), (g >= 0) ? 32'(wdata_of(g)) : 32'd0);
    check("ram_save", 32'(ram_save), (g >= 0) ? 32'(we[g]) : 32'd0);
    check("busy", 32'(busy), 32'(|req));
    check("rvalid", 32'(rvalid), 32'(erv));
    if (g >= 0) check("owner", 32'(owner), 32'(g));
    if (m_rv >= 0) check("rdata", 32'(rdata), 32'(m_rdata));
    @(posedge clk);
    m_edge(g);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      exp_mem[i] = 8'(i * 7 + 3);
    end
    mem[16'h1234]     = 8'h5A;
    exp_mem[16'h1234] = 8'h5A;
    m_ptr = 0; m_last = 0; m_hold = 0; m_lockv = 0; m_rv = -1; m_rdata = '0;
    res = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

    // Reset state.
    repeat (2) cycle();
    res = 1'b1;

    // Single read.
    req = 3'b001; set_ch(0, 16'h1234, 8'h00);
    cycle();
    check("single_rd_rvalid", 32'(rvalid), 32'h1);
    check("single_rd_rdata", 32'(rdata), 32'h5A);
    req = '0;
    cycle();

    // Round-robin with everyone requesting.
    req = 3'b111; set_ch(1, 16'h0010, 8'h00); set_ch(2, 16'h0020, 8'h00);
    repeat (6) cycle();

    // Lock bound: requester 1 bursts while 0 and 2 keep asking.
    req = 3'b001; cycle();
    req = 3'b111; lock = 3'b010;
    repeat (8) cycle();
    lock = '0; req = '0; cycle();

    // Write then read back.
    req = 3'b100; we = 3'b100; set_ch(2, 16'h00FF, 8'hC3);
    cycle();
    check("wr_no_rvalid", 32'(rvalid), 32'h0);
    req = 3'b001; we = '0; set_ch(0, 16'h00FF, 8'h00);
    cycle();
    check("wr_rd_rvalid", 32'(rvalid), 32'h1);
    check("wr_rd_rdata", 32'(rdata), 32'hC3);

    // Reset right after an accepted read.
    req = 3'b001; cycle();
    res = 1'b0; req = 3'b111;
    repeat (3) cycle();
    res = 1'b1;
    cycle();
    check("post_reset_owner", 32'(rvalid), 32'h1);

    // Lock release: owner drops req while 0 waits.
    req = 3'b010; lock = 3'b010; repeat (2) cycle();
    req = 3'b011; cycle();
    req = 3'b001; lock = '0; cycle();
    req = '0; cycle();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      res  = ($urandom_range(0, 59) != 0);
      req  = N'($urandom);
      lock = ($urandom_range(0, 2) != 0) ? N'($urandom) : '0;
      we   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        set_ch(i, ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31)),
               DW'($urandom));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
